// File: rtl/lsu_store_buffer.sv
// Quadword-granular store buffer: aligns e0 stores into byte lanes, forwards to e0 loads
// with e1 results, and drains committed entries in order through a valid/ack retire port.
module lsu_store_buffer #(
   parameter int DEPTH   = 4,
   parameter int VA_BITS = 32
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               store_e0,
   input  logic               load_e0,
   input  logic [1:0]         op_size_e0,
   input  logic [VA_BITS-1:0] va_e0,
   input  logic [63:0]        store_data_e0,
   input  logic               dealloc_e1,
   output logic               stb_full,
   output logic               stb_empty,
   output logic               stb_hit_e1,
   output logic               stb_fail_e1,
   output logic [63:0]        stb_data_e1,
   output logic               rtr_st_vld_xx,
   output logic [7:0]         rtr_st_be_xx,
   output logic [63:0]        rtr_st_data_xx,
   output logic [VA_BITS-1:0] rtr_st_addr_xx,
   input  logic               rtr_st_ack_xx
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   localparam logic [1:0] OP_SZ_BYTE = 2'd0;
   localparam logic [1:0] OP_SZ_WORD = 2'd1;
   localparam logic [1:0] OP_SZ_LWRD = 2'd2;
   localparam logic [1:0] OP_SZ_QWRD = 2'd3;

   logic          vld_reg  [DEPTH];
   logic          cmt_reg  [DEPTH];
   logic [28:0]   tag_reg  [DEPTH];
   logic [7:0]    be_reg   [DEPTH];
   logic [63:0]   data_reg [DEPTH];

   logic [PW-1:0] head_reg;
   logic [PW-1:0] tail_reg;
   logic [CW-1:0] count_reg;
   logic          alloc_e1_reg;
   logic [PW-1:0] alloc_idx_e1_reg;
   logic          hit_reg;
   logic          fail_reg;
   logic [63:0]   fwd_data_reg;

   logic [28:0]   va_tag;
   logic [2:0]    va_off;
   logic [7:0]    size_mask;
   logic [7:0]    lane_be;
   logic [63:0]   lane_data;
   logic          full;
   logic          alloc;
   logic          dealloc;
   logic          pop;
   logic [PW-1:0] alloc_idx;
   logic [DEPTH-1:0] match;
   logic          fwd_found;
   logic [PW-1:0] fwd_age;
   logic [7:0]    fwd_be;
   logic [63:0]   fwd_data;
   logic          hit_next;
   logic          fail_next;

   assign va_tag = va_e0[31:3];
   assign va_off = va_e0[2:0];

   always_comb begin
      size_mask = 8'h01;
      case (op_size_e0)
         OP_SZ_BYTE: size_mask = 8'h01;
         OP_SZ_WORD: size_mask = 8'h03;
         OP_SZ_LWRD: size_mask = 8'h0F;
         OP_SZ_QWRD: size_mask = 8'hFF;
         default:    size_mask = 8'h01;
      endcase
   end

   // Bytes shifted past the quadword are dropped; misalignment traps upstream.
   assign lane_be   = size_mask << va_off;
   assign lane_data = store_data_e0 << {va_off, 3'b000};

   assign full      = (count_reg == CW'(DEPTH));
   assign stb_full  = full;
   assign stb_empty = (count_reg == '0);

   assign alloc   = store_e0 & ~full;
   assign dealloc = dealloc_e1 & alloc_e1_reg;
   assign pop     = rtr_st_vld_xx & rtr_st_ack_xx;
   // A store squashed this cycle frees tail-1, which a new store reuses immediately.
   assign alloc_idx = dealloc ? (tail_reg - PW'(1)) : tail_reg;

   genvar gi;
   generate
      for (gi = 0; gi < DEPTH; gi++) begin : g_match
         assign match[gi] = vld_reg[gi] && (tag_reg[gi] == va_tag);
      end
   endgenerate

   // Youngest matching entry is the one furthest from head, independent of raw index.
   always_comb begin
      fwd_found = 1'b0;
      fwd_age   = '0;
      fwd_be    = '0;
      fwd_data  = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (match[i] && (!fwd_found || (PW'(i) - head_reg) > fwd_age)) begin
            fwd_found = 1'b1;
            fwd_age   = PW'(i) - head_reg;
            fwd_be    = be_reg[i];
            fwd_data  = data_reg[i];
         end
      end
   end

   assign hit_next  = load_e0 & fwd_found & ((fwd_be & lane_be) == lane_be);
   assign fail_next = (load_e0 & fwd_found & ((fwd_be & lane_be) != lane_be))
                    | (store_e0 & full);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         head_reg         <= '0;
         tail_reg         <= '0;
         count_reg        <= '0;
         alloc_e1_reg     <= 1'b0;
         alloc_idx_e1_reg <= '0;
         hit_reg          <= 1'b0;
         fail_reg         <= 1'b0;
         fwd_data_reg     <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            vld_reg[i]  <= 1'b0;
            cmt_reg[i]  <= 1'b0;
            tag_reg[i]  <= '0;
            be_reg[i]   <= '0;
            data_reg[i] <= '0;
         end
      end else begin
         head_reg         <= head_reg + PW'(pop);
         tail_reg         <= alloc_idx + PW'(alloc);
         count_reg        <= count_reg + CW'(alloc) - CW'(dealloc) - CW'(pop);
         alloc_e1_reg     <= alloc;
         alloc_idx_e1_reg <= alloc_idx;
         hit_reg          <= hit_next;
         fail_reg         <= fail_next;
         fwd_data_reg     <= hit_next ? fwd_data : 64'd0;
         for (int i = 0; i < DEPTH; i++) begin
            if (pop && head_reg == PW'(i)) begin
               vld_reg[i] <= 1'b0;
               cmt_reg[i] <= 1'b0;
            end
            if (alloc_e1_reg && alloc_idx_e1_reg == PW'(i)) begin
               if (dealloc_e1) vld_reg[i] <= 1'b0;
               else            cmt_reg[i] <= 1'b1;
            end
            if (alloc && alloc_idx == PW'(i)) begin
               vld_reg[i]  <= 1'b1;
               cmt_reg[i]  <= 1'b0;
               tag_reg[i]  <= va_tag;
               be_reg[i]   <= lane_be;
               data_reg[i] <= lane_data;
            end
         end
      end
   end

   assign stb_hit_e1     = hit_reg;
   assign stb_fail_e1    = fail_reg;
   assign stb_data_e1    = fwd_data_reg;
   assign rtr_st_vld_xx  = vld_reg[head_reg] & cmt_reg[head_reg];
   assign rtr_st_be_xx   = be_reg[head_reg];
   assign rtr_st_data_xx = data_reg[head_reg];
   assign rtr_st_addr_xx = VA_BITS'({tag_reg[head_reg], 3'b000});

endmodule

// File: tb/tb_lsu_store_buffer.sv
// Directed bench for lsu_store_buffer: queue-based reference model checked every cycle,
// plus hand-computed literal expectations for each scenario.
module tb_lsu_store_buffer;

   localparam int DEPTH = 4;
   localparam logic [1:0] SZ_B = 2'd0, SZ_W = 2'd1, SZ_L = 2'd2, SZ_Q = 2'd3;

   logic        clk = 1'b0;
   logic        reset_n = 1'b1;
   logic        store_e0 = 1'b0;
   logic        load_e0 = 1'b0;
   logic [1:0]  op_size_e0 = '0;
   logic [31:0] va_e0 = '0;
   logic [63:0] store_data_e0 = '0;
   logic        dealloc_e1 = 1'b0;
   logic        rtr_st_ack_xx = 1'b0;
   logic        stb_full, stb_empty, stb_hit_e1, stb_fail_e1, rtr_st_vld_xx;
   logic [63:0] stb_data_e1, rtr_st_data_xx;
   logic [7:0]  rtr_st_be_xx;
   logic [31:0] rtr_st_addr_xx;

   int checks = 0;
   int errors = 0;

   lsu_store_buffer #(.DEPTH(DEPTH), .VA_BITS(32)) dut (
      .clk(clk), .reset_n(reset_n), .store_e0(store_e0), .load_e0(load_e0),
      .op_size_e0(op_size_e0), .va_e0(va_e0), .store_data_e0(store_data_e0),
      .dealloc_e1(dealloc_e1), .stb_full(stb_full), .stb_empty(stb_empty),
      .stb_hit_e1(stb_hit_e1), .stb_fail_e1(stb_fail_e1), .stb_data_e1(stb_data_e1),
      .rtr_st_vld_xx(rtr_st_vld_xx), .rtr_st_be_xx(rtr_st_be_xx),
      .rtr_st_data_xx(rtr_st_data_xx), .rtr_st_addr_xx(rtr_st_addr_xx),
      .rtr_st_ack_xx(rtr_st_ack_xx)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [28:0] tag;
      logic [7:0]  be;
      logic [63:0] data;
      bit          cmt;
   } ent_t;

   ent_t        q[$];
   bit          m_pend = 0;
   bit          m_hit = 0;
   bit          m_fail = 0;
   logic [63:0] m_data = '0;

   function automatic logic [7:0] need_mask(input logic [1:0] sz, input logic [2:0] off);
      logic [7:0] base;
      case (sz)
         SZ_B: base = 8'h01;
         SZ_W: base = 8'h03;
         SZ_L: base = 8'h0F;
         default: base = 8'hFF;
      endcase
      return base << off;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: queue ordered oldest first, updated on every clock edge.
   initial begin
      bit   was_full, do_pop, found;
      ent_t c, n;
      logic [7:0] need;
      forever begin
         @(posedge clk or negedge reset_n);
         if (!reset_n) begin
            q.delete();
            m_pend = 0; m_hit = 0; m_fail = 0; m_data = '0;
         end else begin
            was_full = (q.size() == DEPTH);
            do_pop   = rtr_st_ack_xx && q.size() > 0 && q[0].cmt;
            m_hit = 0; m_fail = 0; m_data = '0; found = 0;
            if (load_e0) begin
               need = need_mask(op_size_e0, va_e0[2:0]);
               for (int i = q.size() - 1; i >= 0; i--) begin
                  if (!found && q[i].tag == va_e0[31:3]) begin
                     c = q[i];
                     found = 1;
                  end
               end
               if (found) begin
                  if ((c.be & need) == need) begin
                     m_hit = 1;
                     m_data = c.data;
                  end else begin
                     m_fail = 1;
                  end
               end
            end
            if (store_e0 && was_full) m_fail = 1;
            if (m_pend) begin
               if (dealloc_e1) q.pop_back();
               else q[q.size() - 1].cmt = 1;
            end
            if (do_pop) q.pop_front();
            m_pend = 0;
            if (store_e0 && !was_full) begin
               n.tag  = va_e0[31:3];
               n.be   = need_mask(op_size_e0, va_e0[2:0]);
               n.data = store_data_e0 << (8 * int'(va_e0[2:0]));
               n.cmt  = 0;
               q.push_back(n);
               m_pend = 1;
            end
         end
      end
   end

   // Per-cycle comparison against the model, sampled on the falling edge.
   initial begin
      bit ev;
      forever begin
         @(negedge clk);
         if (reset_n) begin
            ev = (q.size() > 0) && q[0].cmt;
            chk("m_full", stb_full, 64'(q.size() == DEPTH));
            chk("m_empty", stb_empty, 64'(q.size() == 0));
            chk("m_hit", stb_hit_e1, 64'(m_hit));
            chk("m_fail", stb_fail_e1, 64'(m_fail));
            chk("m_fwd_data", stb_data_e1, m_data);
            chk("m_rtr_vld", rtr_st_vld_xx, 64'(ev));
            if (ev) begin
               chk("m_rtr_be", rtr_st_be_xx, 64'(q[0].be));
               chk("m_rtr_data", rtr_st_data_xx, q[0].data);
               chk("m_rtr_addr", rtr_st_addr_xx, 64'({q[0].tag, 3'b000}));
            end
         end
      end
   end

   task automatic step(input bit st, input bit ld, input logic [1:0] sz, input logic [31:0] va,
                       input logic [63:0] d, input bit dal, input bit ack);
      store_e0 = st; load_e0 = ld; op_size_e0 = sz; va_e0 = va;
      store_data_e0 = d; dealloc_e1 = dal; rtr_st_ack_xx = ack;
      @(negedge clk);
      store_e0 = 0; load_e0 = 0; op_size_e0 = '0; va_e0 = '0;
      store_data_e0 = '0; dealloc_e1 = 0; rtr_st_ack_xx = 0;
      $display("step st=%0b ld=%0b sz=%0d va=%h d=%h dal=%0b ack=%0b -> full=%0b empty=%0b hit=%0b fail=%0b fwd=%h rvld=%0b raddr=%h",
               st, ld, sz, va, d, dal, ack, stb_full, stb_empty, stb_hit_e1, stb_fail_e1,
               stb_data_e1, rtr_st_vld_xx, rtr_st_addr_xx);
   endtask

   task automatic idle(input bit ack);
      step(0, 0, SZ_B, 32'h0, 64'h0, 0, ack);
   endtask

   task automatic chk_reset_values(input string tag);
      chk({tag, "_full"}, stb_full, 64'h0);
      chk({tag, "_empty"}, stb_empty, 64'h1);
      chk({tag, "_hit"}, stb_hit_e1, 64'h0);
      chk({tag, "_fail"}, stb_fail_e1, 64'h0);
      chk({tag, "_data"}, stb_data_e1, 64'h0);
      chk({tag, "_rvld"}, rtr_st_vld_xx, 64'h0);
   endtask

   logic [63:0] fwd;
   logic [31:0] exp_addr [3];
   logic [63:0] exp_dat  [3];

   initial begin
      #1 reset_n = 1'b0;
      #10 chk_reset_values("reset");
      @(negedge clk);
      #2 reset_n = 1'b1;
      @(negedge clk);

      // Quadword store retires two cycles after issue.
      step(1, 0, SZ_Q, 32'h100, 64'h1122334455667788, 0, 0);
      chk("stq_not_empty", stb_empty, 64'h0);
      chk("stq_uncommitted", rtr_st_vld_xx, 64'h0);
      idle(0);
      chk("stq_rvld", rtr_st_vld_xx, 64'h1);
      chk("stq_addr", rtr_st_addr_xx, 64'h100);
      chk("stq_be", rtr_st_be_xx, 64'hFF);
      chk("stq_data", rtr_st_data_xx, 64'h1122334455667788);
      idle(1);
      chk("stq_drained", stb_empty, 64'h1);

      // Byte store forwarded to a covered byte load, partial coverage replays.
      step(1, 0, SZ_B, 32'h103, 64'hAB, 0, 0);
      idle(0);
      chk("stb_be", rtr_st_be_xx, 64'h08);
      step(0, 1, SZ_B, 32'h103, 64'h0, 0, 0);
      fwd = stb_data_e1;
      chk("ldbu_hit", stb_hit_e1, 64'h1);
      chk("ldbu_byte", 64'(fwd[31:24]), 64'hAB);
      step(0, 1, SZ_L, 32'h100, 64'h0, 0, 0);
      chk("ldl_fail", stb_fail_e1, 64'h1);
      chk("ldl_nohit", stb_hit_e1, 64'h0);
      idle(1);
      chk("stb_drained", stb_empty, 64'h1);

      // Youngest of two overlapping stores supplies forwarded data.
      step(1, 0, SZ_L, 32'h208, 64'h11223344, 0, 0);
      step(1, 0, SZ_W, 32'h20A, 64'hBEEF, 0, 0);
      step(0, 1, SZ_W, 32'h20A, 64'h0, 0, 0);
      fwd = stb_data_e1;
      chk("ldw_hit", stb_hit_e1, 64'h1);
      chk("ldw_young", 64'(fwd[31:16]), 64'hBEEF);
      idle(1);
      idle(1);
      chk("ldw_drained", stb_empty, 64'h1);

      // Squash the first store while issuing a second into the freed slot.
      step(1, 0, SZ_Q, 32'h300, 64'hAAAA, 0, 0);
      step(1, 0, SZ_Q, 32'h308, 64'hBBBB, 1, 0);
      chk("dal_one_entry", stb_empty, 64'h0);
      chk("dal_pending", rtr_st_vld_xx, 64'h0);
      idle(0);
      chk("dal_rvld", rtr_st_vld_xx, 64'h1);
      chk("dal_addr", rtr_st_addr_xx, 64'h308);
      chk("dal_data", rtr_st_data_xx, 64'hBBBB);
      idle(1);
      chk("dal_single", stb_empty, 64'h1);

      // Fill across the pointer wrap, reject when full, then drain in order.
      step(1, 0, SZ_Q, 32'h400, 64'hD1, 0, 0);
      step(1, 0, SZ_Q, 32'h408, 64'hD2, 0, 0);
      step(1, 0, SZ_Q, 32'h410, 64'h1111, 0, 0);
      step(1, 0, SZ_Q, 32'h410, 64'h2222, 0, 0);
      chk("fill_full", stb_full, 64'h1);
      step(1, 0, SZ_Q, 32'h418, 64'hD5, 0, 0);
      chk("rej_fail", stb_fail_e1, 64'h1);
      chk("rej_still_full", stb_full, 64'h1);
      step(1, 0, SZ_Q, 32'h418, 64'hD6, 0, 1);
      chk("rej_pop_fail", stb_fail_e1, 64'h1);
      chk("rej_pop_not_full", stb_full, 64'h0);
      step(0, 1, SZ_Q, 32'h410, 64'h0, 0, 0);
      chk("wrap_hit", stb_hit_e1, 64'h1);
      chk("wrap_young", stb_data_e1, 64'h2222);
      exp_addr[0] = 32'h408; exp_dat[0] = 64'hD2;
      exp_addr[1] = 32'h410; exp_dat[1] = 64'h1111;
      exp_addr[2] = 32'h410; exp_dat[2] = 64'h2222;
      for (int k = 0; k < 3; k++) begin
         chk("drain_addr", rtr_st_addr_xx, 64'(exp_addr[k]));
         chk("drain_data", rtr_st_data_xx, exp_dat[k]);
         idle(1);
      end
      chk("drain_empty", stb_empty, 64'h1);

      // Asynchronous reset with three entries queued and a live forward.
      step(1, 0, SZ_Q, 32'h500, 64'h5, 0, 0);
      step(1, 0, SZ_Q, 32'h508, 64'h6, 0, 0);
      step(1, 0, SZ_Q, 32'h510, 64'h7, 0, 0);
      step(0, 1, SZ_Q, 32'h508, 64'h0, 0, 0);
      chk("pre_rst_hit", stb_hit_e1, 64'h1);
      chk("pre_rst_rvld", rtr_st_vld_xx, 64'h1);
      #2 reset_n = 1'b0;
      #1 chk_reset_values("async_rst");
      rtr_st_ack_xx = 1'b1;
      @(negedge clk);
      chk("rst_no_retire", rtr_st_vld_xx, 64'h0);
      #2 reset_n = 1'b1;
      rtr_st_ack_xx = 1'b0;
      @(negedge clk);
      idle(1);
      chk("post_rst_empty", stb_empty, 64'h1);
      chk("post_rst_rvld", rtr_st_vld_xx, 64'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
